mul_share_arb: RTL and testbench

Scheduler that shares one pipelined unsigned multiplier (14-bit × 16-bit, 29-bit product, 4-stage, ce-gated, no reset on its datapath) between NREQ requesters. It arbitrates operand requests and drives the multiplier's ce and operand inputs. It tracks each in-flight operation's requester ID in a shadow valid/ID pipeline and returns tagged results on a single response port with backpressure. It sits between the patch-geometry stages that issue multiplies and the shared multiplier instance.

---
 rtl/mul_arb_pkg.sv | 24 ++
 rtl/mul_arb_pick.sv | 60 ++++++
 rtl/mul_share_arb.sv | 125 ++++++++++++
 tb/tb_mul_share_arb.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the multiplier-sharing scheduler.
//   NREQ, A_W, B_W, P_W, LAT : default configuration of mul_share_arb
//   id_t, tag_t              : requester ID and shadow tag for the default NREQ
//   id_width()               : ID width, never below one bit
package mul_arb_pkg;

    localparam int unsigned NREQ = 4;
    localparam int unsigned A_W  = 14;
    localparam int unsigned B_W  = 16;
    localparam int unsigned P_W  = 29;
    localparam int unsigned LAT  = 4;

    typedef logic [$clog2(NREQ)-1:0] id_t;

    typedef struct packed {
        logic vld;
        id_t  id;
    } tag_t;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_arb_pick.sv
// Grant selector for mul_share_arb.
//   req_valid : per-requester valid
//   ptr       : round-robin search start (ignored in fixed-priority build)
//   en        : grant enable; no grant is made while low
//   grant_any : a requester was granted
//   g         : granted index (0 when grant_any is low)
// Build option: MUL_ARB_RR_EN selects round-robin, otherwise lowest index wins.
module mul_arb_pick import mul_arb_pkg::*; #(
    parameter int unsigned NREQ = mul_arb_pkg::NREQ,
    parameter int unsigned IdW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IdW-1:0]  ptr,
    input  logic            en,
    output logic            grant_any,
    output logic [IdW-1:0]  g
);

`ifdef MUL_ARB_RR_EN
    // Rotate so bit 0 is the requester at ptr; first set bit is the winner.
    logic [2*NREQ-1:0] rot;
    logic [IdW:0]      sum;

    always_comb begin
        grant_any = 1'b0;
        g         = '0;
        sum       = '0;
        rot       = {req_valid, req_valid} >> ptr;
        if (en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!grant_any && rot[k]) begin
                    grant_any = 1'b1;
                    sum       = {1'b0, ptr} + (IdW+1)'(k);
                    if (sum >= (IdW+1)'(NREQ)) begin
                        sum = sum - (IdW+1)'(NREQ);
                    end
                    g = IdW'(sum);
                end
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        grant_any = 1'b0;
        g         = '0;
        if (en) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (!grant_any && req_valid[k]) begin
                    grant_any = 1'b1;
                    g         = IdW'(k);
                end
            end
        end
    end
`endif

endmodule

// File: rtl/mul_share_arb.sv
// Shares one ce-gated pipelined multiplier between NREQ requesters.
//   clk, reset_n           : clock, asynchronous active-low reset
//   req_valid/req_ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b           : packed operands, requester i at [i*W +: W]
//   mul_ce, mul_din0/1     : multiplier enable and operands
//   mul_dout               : multiplier product
//   rsp_valid/rsp_ready    : tagged result handshake
//   rsp_id, rsp_p          : requester ID and product of the result
// Build option: MUL_ARB_RR_EN enables round-robin arbitration with a pointer register.
module mul_share_arb import mul_arb_pkg::*; #(
    parameter int unsigned NREQ = mul_arb_pkg::NREQ,
    parameter int unsigned A_W  = mul_arb_pkg::A_W,
    parameter int unsigned B_W  = mul_arb_pkg::B_W,
    parameter int unsigned P_W  = mul_arb_pkg::P_W,
    parameter int unsigned LAT  = mul_arb_pkg::LAT,
    localparam int unsigned IdW = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*A_W-1:0] req_a,
    input  logic [NREQ*B_W-1:0] req_b,
    output logic              mul_ce,
    output logic [A_W-1:0]    mul_din0,
    output logic [B_W-1:0]    mul_din1,
    input  logic [P_W-1:0]    mul_dout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IdW-1:0]    rsp_id,
    output logic [P_W-1:0]    rsp_p
);

    localparam int unsigned Stg = LAT - 1;

    logic [Stg-1:0]          vld_q, vld_d;
    logic [Stg-1:0][IdW-1:0] id_q, id_d;
    logic                    grant_any;
    logic [IdW-1:0]          g;
    logic [IdW-1:0]          ptr;

    assign rsp_valid = vld_q[Stg-1];
    assign rsp_id    = id_q[Stg-1];
    // Multiplier holds its output while ce=0, so the product is stable in a stall.
    assign rsp_p     = mul_dout;
    assign mul_ce    = !rsp_valid || rsp_ready;

    // Gating with reset_n keeps req_ready and the operands at zero during reset.
    mul_arb_pick #(
        .NREQ (NREQ),
        .IdW  (IdW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .en        (mul_ce && reset_n),
        .grant_any (grant_any),
        .g         (g)
    );

`ifdef MUL_ARB_RR_EN
    logic [IdW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (grant_any) begin
            ptr_d = (g == IdW'(NREQ - 1)) ? '0 : g + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        req_ready = '0;
        if (grant_any) begin
            req_ready[g] = 1'b1;
        end
    end

    always_comb begin
        mul_din0 = '0;
        mul_din1 = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_any && g == IdW'(i)) begin
                mul_din0 = req_a[i*A_W +: A_W];
                mul_din1 = req_b[i*B_W +: B_W];
            end
        end
    end

    // Shadow tag pipe: advances in lockstep with the multiplier stages.
    always_comb begin
        vld_d = vld_q;
        id_d  = id_q;
        if (mul_ce) begin
            vld_d[0] = grant_any;
            id_d[0]  = g;
            for (int unsigned s = 1; s < Stg; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int A_W  = 14;
    localparam int B_W  = 16;
    localparam int P_W  = 29;
    localparam int LAT  = 4;
    localparam int IdW  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*A_W-1:0]    req_a;
    logic [NREQ*B_W-1:0]    req_b;
    logic                   mul_ce;
    logic [A_W-1:0]         mul_din0;
    logic [B_W-1:0]         mul_din1;
    logic [P_W-1:0]         mul_dout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IdW-1:0]         rsp_id;
    logic [P_W-1:0]         rsp_p;

    always #5 clk = ~clk;

    mul_share_arb #(
        .NREQ (NREQ),
        .A_W  (A_W),
        .B_W  (B_W),
        .P_W  (P_W),
        .LAT  (LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p)
    );

    // Shared multiplier: LAT-1 ce-gated register stages, no reset.
    logic [P_W-1:0] mp [LAT-1];
    always @(posedge clk) begin
        if (mul_ce) begin
            mp[0] <= P_W'(64'(mul_din0) * 64'(mul_din1));
            for (int s = 1; s < LAT - 1; s++) mp[s] <= mp[s-1];
        end
    end
    assign mul_dout = mp[LAT-2];

    // Reference model: queue of accepted operations in issue order.
    typedef struct {
        int          id;
        logic [63:0] p;
        int          t;
    } op_t;

    op_t q[$];
    int  ce_cnt;
    int  rr;
    int  ntot;
    int  npass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int pick(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++) begin
`ifdef MUL_ARB_RR_EN
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
`else
            if (v[k]) return k;
`endif
        end
        return -1;
    endfunction

    task automatic set_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*A_W +: A_W] = A_W'($urandom);
            req_b[i*B_W +: B_W] = B_W'($urandom);
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic tick();
        int              gi;
        logic            ev;
        logic            ece;
        logic [NREQ-1:0] erdy;
        logic [63:0]     a;
        logic [63:0]     b;
        op_t             op;
        @(negedge clk);
        gi   = -1;
        ev   = 1'b0;
        erdy = '0;
        if (!reset_n) begin
            ece = 1'b1;
        end else begin
            if (q.size() > 0) begin
                if (ce_cnt - q[0].t == LAT - 2) ev = 1'b1;
            end
            ece = !ev || rsp_ready;
            if (ece) gi = pick(req_valid);
            if (gi >= 0) erdy[gi] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(erdy));
        check("mul_ce", 64'(mul_ce), 64'(ece));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        if (ev) begin
            check("rsp_id", 64'(rsp_id), 64'(q[0].id));
            check("rsp_p", 64'(rsp_p), q[0].p);
        end
        if (gi >= 0) begin
            a = 64'(req_a[gi*A_W +: A_W]);
            b = 64'(req_b[gi*B_W +: B_W]);
            check("mul_din0", 64'(mul_din0), a);
            check("mul_din1", 64'(mul_din1), b);
        end
        @(posedge clk);
        if (reset_n && ece) begin
            if (ev) void'(q.pop_front());
            ce_cnt++;
            if (gi >= 0) begin
                op.id = gi;
                op.p  = (a * b) & ((64'd1 << P_W) - 64'd1);
                op.t  = ce_cnt;
                q.push_back(op);
                rr = (gi + 1) % NREQ;
            end
        end
        #1;
    endtask

    initial begin
        ntot      = 0;
        npass     = 0;
        ce_cnt    = 0;
        rr        = 0;
        reset_n   = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_mul_ce", 64'(mul_ce), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;

        // Requester 0 alone: 3*5.
        req_a[0 +: A_W] = 14'd3;
        req_b[0 +: B_W] = 16'd5;
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // All requesters valid, no backpressure.
        req_valid = '1;
        repeat (12) begin
            set_ops();
            tick();
        end

        // Full pipeline, then five stalled cycles, then drain.
        repeat (5) begin
            set_ops();
            tick();
        end
        rsp_ready = 1'b0;
        repeat (5) begin
            set_ops();
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (6) tick();

        // Largest operands: product is truncated to P_W bits.
        req_a[1*A_W +: A_W] = 14'd16383;
        req_b[1*B_W +: B_W] = 16'd65535;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (4) tick();

        // Requester 2 raises valid as a result appears with rsp_ready low.
        req_valid = 4'b0001;
        set_ops();
        tick();
        req_valid = '0;
        tick();
        tick();
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        tick();
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        repeat (5) tick();

        // Random traffic with random backpressure.
        repeat (300) begin
            req_valid = NREQ'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            set_ops();
            tick();
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        repeat (6) tick();

        // Asynchronous reset with three operations in flight.
        req_valid = '1;
        repeat (3) begin
            set_ops();
            tick();
        end
        #3;
        reset_n = 1'b0;
        #1;
        check("async_rsp_valid", 64'(rsp_valid), 64'd0);
        check("async_req_ready", 64'(req_ready), 64'd0);
        check("async_mul_ce", 64'(mul_ce), 64'd1);
        check("async_din0", 64'(mul_din0), 64'd0);
        check("async_din1", 64'(mul_din1), 64'd0);
        check("async_rsp_id", 64'(rsp_id), 64'd0);
        q.delete();
        rr = 0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) begin
            set_ops();
            tick();
        end
        req_valid = '0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
